// File: rtl/kamus_mem.sv
// Memory-access stage: drives L1D loads/stores over req/gnt/rvalid and owns the MEM/WB register.
// Optional macro KAMUS_MISALIGN_TRAP_EN traps misaligned half/word accesses instead of aligning them down.
module kamus_mem #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            valid_exmem_reg_i,
  input  logic            regfile_wr_en_exmem_reg_i,
  input  logic [XLEN-1:0] alu_exmem_reg_i,
  input  logic [XLEN-1:0] rs2_data_exmem_reg_i,
  input  logic            mem_rd_en_exmem_reg_i,
  input  logic            mem_wr_en_exmem_reg_i,
  input  logic [1:0]      mem_size_exmem_reg_i,
  input  logic            mem_unsigned_exmem_reg_i,
  input  logic [1:0]      wb_mux_sel_exmem_reg_i,
  input  logic [4:0]      rd_addr_exmem_reg_i,
  output logic            l1d_req_o,
  output logic            l1d_we_o,
  output logic [XLEN-1:0] l1d_addr_o,
  output logic [3:0]      l1d_be_o,
  output logic [XLEN-1:0] l1d_wr_data_o,
  input  logic            l1d_gnt_i,
  input  logic            l1d_rvalid_i,
  input  logic [XLEN-1:0] l1d_rd_data_i,
  output logic            mem_stall_o,
  output logic            regfile_wr_en_memwb_reg_o,
  output logic [XLEN-1:0] alu_memwb_reg_o,
  output logic [XLEN-1:0] l1d_rd_data_memwb_reg_o,
  output logic [1:0]      wb_mux_sel_memwb_reg_o,
  output logic [4:0]      rd_addr_memwb_reg_o,
`ifdef KAMUS_MISALIGN_TRAP_EN
  output logic            misalign_exc_o,
`endif
  output logic [1:0]      state_dbg_o
);

  // Handshake: a request is accepted in the cycle req && gnt are both high; req and its
  // addr/we/be/data stay stable until then. rvalid is honoured only in WAIT_RVALID.
  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    WAIT_GNT    = 2'd1,
    WAIT_RVALID = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic            mem_op, misalign, access, done, req;
  logic [1:0]      sh;
  logic [XLEN-1:0] lane, ld_data;

  assign mem_op = valid_exmem_reg_i & (mem_rd_en_exmem_reg_i | mem_wr_en_exmem_reg_i);

`ifdef KAMUS_MISALIGN_TRAP_EN
  always_comb begin
    misalign = 1'b0;
    case (mem_size_exmem_reg_i)
      2'b00:   misalign = 1'b0;
      2'b01:   misalign = alu_exmem_reg_i[0];
      default: misalign = |alu_exmem_reg_i[1:0];
    endcase
  end
`else
  assign misalign = 1'b0;
`endif

  assign access = mem_op & ~misalign;

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    req     = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      IDLE, WAIT_GNT: begin
        if (access) begin
          req = 1'b1;
          if (l1d_gnt_i) begin
            if (mem_rd_en_exmem_reg_i) begin
              state_d = WAIT_RVALID;
            end else begin
              done    = 1'b1;
              state_d = IDLE;
            end
          end else begin
            state_d = WAIT_GNT;
          end
        end
      end
      WAIT_RVALID: begin
        if (l1d_rvalid_i) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset masks the combinational outputs so a held EX/MEM op cannot re-request mid-reset.
  assign l1d_req_o   = req & ~rst_i;
  assign mem_stall_o = access & ~done & ~rst_i;
  assign state_dbg_o = state_q;

  assign l1d_we_o   = mem_wr_en_exmem_reg_i;
  assign l1d_addr_o = {alu_exmem_reg_i[XLEN-1:2], 2'b00};

  always_comb begin
    l1d_be_o      = 4'b1111;
    l1d_wr_data_o = rs2_data_exmem_reg_i;
    sh            = 2'b00;
    case (mem_size_exmem_reg_i)
      2'b00: begin
        l1d_be_o      = 4'b0001 << alu_exmem_reg_i[1:0];
        l1d_wr_data_o = {4{rs2_data_exmem_reg_i[7:0]}};
        sh            = alu_exmem_reg_i[1:0];
      end
      2'b01: begin
        l1d_be_o      = 4'b0011 << {alu_exmem_reg_i[1], 1'b0};
        l1d_wr_data_o = {2{rs2_data_exmem_reg_i[15:0]}};
        sh            = {alu_exmem_reg_i[1], 1'b0};
      end
      default: ;
    endcase
    lane = l1d_rd_data_i >> {sh, 3'b000};
    case (mem_size_exmem_reg_i)
      2'b00:   ld_data = mem_unsigned_exmem_reg_i ? {{(XLEN-8){1'b0}}, lane[7:0]}
                                                  : {{(XLEN-8){lane[7]}}, lane[7:0]};
      2'b01:   ld_data = mem_unsigned_exmem_reg_i ? {{(XLEN-16){1'b0}}, lane[15:0]}
                                                  : {{(XLEN-16){lane[15]}}, lane[15:0]};
      default: ld_data = lane;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      regfile_wr_en_memwb_reg_o <= 1'b0;
      alu_memwb_reg_o           <= '0;
      l1d_rd_data_memwb_reg_o   <= '0;
      wb_mux_sel_memwb_reg_o    <= '0;
      rd_addr_memwb_reg_o       <= '0;
`ifdef KAMUS_MISALIGN_TRAP_EN
      misalign_exc_o            <= 1'b0;
`endif
    end else if (mem_stall_o) begin
      regfile_wr_en_memwb_reg_o <= 1'b0;
`ifdef KAMUS_MISALIGN_TRAP_EN
      misalign_exc_o            <= 1'b0;
`endif
    end else begin
      regfile_wr_en_memwb_reg_o <= valid_exmem_reg_i & regfile_wr_en_exmem_reg_i
                                   & ~(mem_op & misalign);
      alu_memwb_reg_o           <= alu_exmem_reg_i;
      wb_mux_sel_memwb_reg_o    <= wb_mux_sel_exmem_reg_i;
      rd_addr_memwb_reg_o       <= rd_addr_exmem_reg_i;
      if (done && mem_rd_en_exmem_reg_i) l1d_rd_data_memwb_reg_o <= ld_data;
`ifdef KAMUS_MISALIGN_TRAP_EN
      misalign_exc_o            <= mem_op & misalign;
`endif
    end
  end

endmodule

// File: tb/tb_kamus_mem.sv
// Self-checking bench for kamus_mem: directed L1D handshake scenarios plus random ops,
// write-back results checked through an expected-value scoreboard queue.
module tb_kamus_mem;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        valid, wr_en, rd_en, st_en, uns;
  logic [31:0] alu, rs2;
  logic [1:0]  size, sel;
  logic [4:0]  rd;
  logic        l1d_req_o, l1d_we_o, l1d_gnt_i, l1d_rvalid_i;
  logic [31:0] l1d_addr_o, l1d_wr_data_o, l1d_rd_data_i;
  logic [3:0]  l1d_be_o;
  logic        mem_stall_o, regfile_wr_en_memwb_reg_o;
  logic [31:0] alu_memwb_reg_o, l1d_rd_data_memwb_reg_o;
  logic [1:0]  wb_mux_sel_memwb_reg_o, state_dbg_o;
  logic [4:0]  rd_addr_memwb_reg_o;
`ifdef KAMUS_MISALIGN_TRAP_EN
  logic        misalign_exc_o;
`endif

  // entry = {wb_mux_sel, rd_addr, alu, rd_data}
  logic [70:0] exp_q[$];
  logic [31:0] last_ld;
  int          n_checks = 0;
  int          n_pass   = 0;

  always #5 clk = ~clk;

  kamus_mem dut (
    .clk_i                     (clk),
    .rst_i                     (rst_i),
    .valid_exmem_reg_i         (valid),
    .regfile_wr_en_exmem_reg_i (wr_en),
    .alu_exmem_reg_i           (alu),
    .rs2_data_exmem_reg_i      (rs2),
    .mem_rd_en_exmem_reg_i     (rd_en),
    .mem_wr_en_exmem_reg_i     (st_en),
    .mem_size_exmem_reg_i      (size),
    .mem_unsigned_exmem_reg_i  (uns),
    .wb_mux_sel_exmem_reg_i    (sel),
    .rd_addr_exmem_reg_i       (rd),
    .l1d_req_o                 (l1d_req_o),
    .l1d_we_o                  (l1d_we_o),
    .l1d_addr_o                (l1d_addr_o),
    .l1d_be_o                  (l1d_be_o),
    .l1d_wr_data_o             (l1d_wr_data_o),
    .l1d_gnt_i                 (l1d_gnt_i),
    .l1d_rvalid_i              (l1d_rvalid_i),
    .l1d_rd_data_i             (l1d_rd_data_i),
    .mem_stall_o               (mem_stall_o),
    .regfile_wr_en_memwb_reg_o (regfile_wr_en_memwb_reg_o),
    .alu_memwb_reg_o           (alu_memwb_reg_o),
    .l1d_rd_data_memwb_reg_o   (l1d_rd_data_memwb_reg_o),
    .wb_mux_sel_memwb_reg_o    (wb_mux_sel_memwb_reg_o),
    .rd_addr_memwb_reg_o       (rd_addr_memwb_reg_o),
`ifdef KAMUS_MISALIGN_TRAP_EN
    .misalign_exc_o            (misalign_exc_o),
`endif
    .state_dbg_o               (state_dbg_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [3:0] exp_be(input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'b00) begin
      case (a[1:0])
        2'd0:    return 4'b0001;
        2'd1:    return 4'b0010;
        2'd2:    return 4'b0100;
        default: return 4'b1000;
      endcase
    end else if (sz == 2'b01) return a[1] ? 4'b1100 : 4'b0011;
    else return 4'b1111;
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [1:0] sz, input logic [31:0] d);
    if (sz == 2'b00)      return {d[7:0], d[7:0], d[7:0], d[7:0]};
    else if (sz == 2'b01) return {d[15:0], d[15:0]};
    else                  return d;
  endfunction

  function automatic logic [31:0] exp_load(input logic [1:0] sz, input logic u,
                                           input logic [31:0] a, input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    case (a[1:0])
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = a[1] ? w[31:16] : w[15:0];
    if (sz == 2'b00)      return u ? {24'h0, b} : {{24{b[7]}}, b};
    else if (sz == 2'b01) return u ? {16'h0, h} : {{16{h[15]}}, h};
    else                  return w;
  endfunction

  function automatic logic is_mis(input logic [1:0] sz, input logic [31:0] a);
`ifdef KAMUS_MISALIGN_TRAP_EN
    if (sz == 2'b00)      return 1'b0;
    else if (sz == 2'b01) return a[0];
    else                  return a[1:0] != 2'b00;
`else
    return (sz == 2'b11) && (a == 32'h1) && 1'b0;
`endif
  endfunction

  // Drives one EX/MEM op and plays the L1D side; gnt arrives gnt_dly cycles after
  // presentation and rvalid rv_dly cycles after gnt. Spurious rvalid is injected
  // while no read is outstanding.
  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic ld, input logic st, input logic [1:0] sz,
                       input logic u, input logic [4:0] r, input int gnt_dly,
                       input int rv_dly, input logic [31:0] rdata);
    logic mem, mis, ereq;
    int   done_cyc;
    mem = ld | st;
    mis = mem && is_mis(sz, a);
    if (!mem || mis) done_cyc = 0;
    else if (st)     done_cyc = gnt_dly;
    else             done_cyc = gnt_dly + rv_dly;
    valid = 1'b1; wr_en = w; alu = a; rs2 = d; rd_en = ld; st_en = st;
    size = sz; uns = u; rd = r; sel = 2'($urandom_range(0, 3));
    if (ld && !mis) last_ld = exp_load(sz, u, a, rdata);
    if (w && !mis) exp_q.push_back({sel, r, a, last_ld});
    for (int c = 0; c <= done_cyc; c++) begin
      l1d_gnt_i    = mem && !mis && (c == gnt_dly);
      l1d_rvalid_i = (ld && !mis && (c == gnt_dly + rv_dly)) ||
                     ((c <= gnt_dly) && ($urandom_range(0, 1) == 1));
      l1d_rd_data_i = (ld && !mis && (c == gnt_dly + rv_dly)) ? rdata : $urandom();
      @(negedge clk);
      ereq = mem && !mis && (c <= gnt_dly);
      chk("stall", 32'(mem_stall_o), 32'(c < done_cyc));
      chk("req", 32'(l1d_req_o), 32'(ereq));
      if (ereq) begin
        chk("addr", l1d_addr_o, {a[31:2], 2'b00});
        chk("be", 32'(l1d_be_o), 32'(exp_be(sz, a)));
        chk("we", 32'(l1d_we_o), 32'(st));
        if (st) chk("wdata", l1d_wr_data_o, exp_wdata(sz, d));
      end
      @(posedge clk); #1;
    end
    l1d_gnt_i = 1'b0; l1d_rvalid_i = 1'b0;
    valid = 1'b0; rd_en = 1'b0; st_en = 1'b0; wr_en = 1'b0;
    chk("wb_en", 32'(regfile_wr_en_memwb_reg_o), 32'(w && !mis));
`ifdef KAMUS_MISALIGN_TRAP_EN
    chk("misalign_exc", 32'(misalign_exc_o), 32'(mis));
`endif
  endtask

  always @(negedge clk) begin
    if (!rst_i && regfile_wr_en_memwb_reg_o) begin
      if (exp_q.size() == 0) begin
        chk("wb_unexpected", 32'(regfile_wr_en_memwb_reg_o), 32'd0);
      end else begin
        logic [70:0] e;
        e = exp_q.pop_front();
        chk("wb_sel", 32'(wb_mux_sel_memwb_reg_o), 32'(e[70:69]));
        chk("wb_rd", 32'(rd_addr_memwb_reg_o), 32'(e[68:64]));
        chk("wb_alu", alu_memwb_reg_o, e[63:32]);
        chk("wb_data", l1d_rd_data_memwb_reg_o, e[31:0]);
      end
    end
  end

  initial begin
    rst_i = 1'b1; valid = 1'b0; wr_en = 1'b0; rd_en = 1'b0; st_en = 1'b0; uns = 1'b0;
    alu = '0; rs2 = '0; size = '0; sel = '0; rd = '0;
    l1d_gnt_i = 1'b0; l1d_rvalid_i = 1'b0; l1d_rd_data_i = '0; last_ld = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req", 32'(l1d_req_o), 32'd0);
    chk("rst_stall", 32'(mem_stall_o), 32'd0);
    chk("rst_state", 32'(state_dbg_o), 32'd0);
    chk("rst_wb_en", 32'(regfile_wr_en_memwb_reg_o), 32'd0);
    chk("rst_alu", alu_memwb_reg_o, 32'd0);
    chk("rst_rdata", l1d_rd_data_memwb_reg_o, 32'd0);
    chk("rst_rd", 32'(rd_addr_memwb_reg_o), 32'd0);
`ifdef KAMUS_MISALIGN_TRAP_EN
    chk("rst_exc", 32'(misalign_exc_o), 32'd0);
`endif
    rst_i = 1'b0;

    issue(1'b1, 32'h1234, 32'h0, 1'b0, 1'b0, 2'b10, 1'b0, 5'd5, 0, 0, 32'h0);
    chk("alu_result", alu_memwb_reg_o, 32'h1234);
    issue(1'b1, 32'h103, 32'h0, 1'b1, 1'b0, 2'b00, 1'b0, 5'd7, 0, 3, 32'h80FF_FFFF);
    chk("lb_data", l1d_rd_data_memwb_reg_o, 32'hFFFF_FF80);
    issue(1'b0, 32'h202, 32'hABCD_1234, 1'b0, 1'b1, 2'b01, 1'b0, 5'd0, 3, 0, 32'h0);
    issue(1'b1, 32'h40, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0, 5'd8, 0, 1, 32'hCAFE_F00D);
    issue(1'b0, 32'h44, 32'h1357_9BDF, 1'b0, 1'b1, 2'b10, 1'b0, 5'd0, 0, 0, 32'h0);
    issue(1'b1, 32'h41, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0, 5'd9, 0, 1, 32'hDEAD_BEEF);

    for (int i = 0; i < 16; i++) begin
      int          kind;
      logic [31:0] ra;
      kind = $urandom_range(0, 2);
      ra   = $urandom();
      issue(kind != 2, ra, $urandom(), kind == 1, kind == 2, 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 5'($urandom_range(1, 31)),
            $urandom_range(0, 3), $urandom_range(1, 3), $urandom());
    end

    // Reset while a load waits for rvalid; the late rvalid must be dropped.
    valid = 1'b1; wr_en = 1'b1; rd_en = 1'b1; size = 2'b01; uns = 1'b1;
    alu = 32'h10; rd = 5'd3; l1d_gnt_i = 1'b1;
    @(negedge clk);
    chk("rst_test_req", 32'(l1d_req_o), 32'd1);
    @(posedge clk); #1;
    l1d_gnt_i = 1'b0; rst_i = 1'b1; valid = 1'b0; rd_en = 1'b0; wr_en = 1'b0;
    @(negedge clk);
    chk("mid_rst_req", 32'(l1d_req_o), 32'd0);
    @(posedge clk); #1;
    rst_i = 1'b0; l1d_rvalid_i = 1'b1; l1d_rd_data_i = 32'h5555_AAAA; last_ld = '0;
    @(negedge clk);
    chk("post_rst_state", 32'(state_dbg_o), 32'd0);
    chk("post_rst_req", 32'(l1d_req_o), 32'd0);
    chk("post_rst_stall", 32'(mem_stall_o), 32'd0);
    chk("post_rst_alu", alu_memwb_reg_o, 32'd0);
    @(posedge clk); #1;
    l1d_rvalid_i = 1'b0;
    chk("late_rvalid_en", 32'(regfile_wr_en_memwb_reg_o), 32'd0);
    chk("late_rvalid_data", l1d_rd_data_memwb_reg_o, 32'd0);
    chk("late_rvalid_state", 32'(state_dbg_o), 32'd0);

    issue(1'b1, 32'h0BAD_F00D, 32'h0, 1'b0, 1'b0, 2'b10, 1'b0, 5'd31, 0, 0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
